gate_resp_checker: RTL

- Response-side counterpart to the gate stimulus benches.
- Samples a 2-input gate DUT's output alongside the applied {a,b} vector and compares it against the expected truth table for a selected gate type.
- Accumulates pass/fail counts and input-combination coverage, then reports an overall verdict.
- Synthesizable, so the same check can run in simulation or on an FPGA harness next to any gate model.

---
 rtl/gate_chk_pkg.sv | 32 +++
 rtl/gate_chk_settle_pipe.sv | 39 +++
 rtl/gate_resp_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared op/state encodings and reference gate function for gate_resp_checker
package gate_chk_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CHECK,
        DRAIN,
        DONE
    } state_t;

    // Reserved ops return 0 here; the checker forces those samples to fail separately.
    function automatic logic exp_gate(input logic [2:0] op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_chk_settle_pipe.sv
// rtl/gate_chk_settle_pipe.sv - SETTLE-deep {valid,a,b} delay line; SETTLE=0 is a passthrough
module gate_chk_settle_pipe #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  logic in_a,
    input  logic in_b,
    output logic out_valid,
    output logic out_a,
    output logic out_b
);

    generate
        if (SETTLE == 0) begin : g_pass
            assign out_valid = in_valid;
            assign out_a     = in_a;
            assign out_b     = in_b;
        end else begin : g_pipe
            logic [2:0] stage [SETTLE];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SETTLE; i++) stage[i] <= '0;
                end else if (flush) begin
                    for (int i = 0; i < SETTLE; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= {in_valid, in_a, in_b};
                    for (int i = 1; i < SETTLE; i++) stage[i] <= stage[i-1];
                end
            end

            assign {out_valid, out_a, out_b} = stage[SETTLE-1];
        end
    endgenerate

endmodule

// File: rtl/gate_resp_checker.sv
// rtl/gate_resp_checker.sv - 2-input gate response checker with pass/fail counts and coverage
// Optional first-mismatch log enabled by GATE_CHK_FAIL_LOG_EN.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             stop,
    input  logic             vec_valid,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       cov,
    output logic             all_pass
`ifdef GATE_CHK_FAIL_LOG_EN
    ,
    output logic [2:0]       fail_vec,
    output logic             fail_seen
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic [2:0] op_q;
    logic [2:0] drain_cnt;
    logic       arm;
    logic       push_v;
    logic       d_valid;
    logic       d_a;
    logic       d_b;
    logic       cmp_en;
    logic       match;

    assign arm    = (state == ARM);
    assign push_v = (state == CHECK) && vec_valid;

    gate_chk_settle_pipe #(
        .SETTLE(SETTLE)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (arm),
        .in_valid (push_v),
        .in_a     (a),
        .in_b     (b),
        .out_valid(d_valid),
        .out_a    (d_a),
        .out_b    (d_b)
    );

    // Vectors pushed late in CHECK land during DRAIN, so both states compare.
    assign cmp_en = d_valid && ((state == CHECK) || (state == DRAIN));
    assign match  = (op_q <= OP_XNOR) && (y == exp_gate(op_q, d_a, d_b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_q      <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= ARM;
                        op_q  <= op;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ARM: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (stop) begin
                        if (SETTLE == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= 3'(SETTLE - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            cov       <= '0;
`ifdef GATE_CHK_FAIL_LOG_EN
            fail_vec  <= '0;
            fail_seen <= 1'b0;
`endif
        end else if (arm) begin
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            cov       <= '0;
`ifdef GATE_CHK_FAIL_LOG_EN
            fail_vec  <= '0;
            fail_seen <= 1'b0;
`endif
        end else if (cmp_en) begin
            if (match) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
`ifdef GATE_CHK_FAIL_LOG_EN
                if (!fail_seen) begin
                    fail_seen <= 1'b1;
                    fail_vec  <= {d_a, d_b, y};
                end
`endif
            end
            cov[{d_a, d_b}] <= 1'b1;
        end
    end

    assign all_pass = done && (fail_cnt == '0) && (cov == 4'hF);

endmodule
